lc3_stage_sequencer: RTL and testbench

//  Central sequencer for the LC3 5-stage datapath (fetch, decode, execute, memaccess, writeback).
//  - Generates per-stage enables and refills the pipeline in order after reset and after branches.
//  - Stalls the pipeline around data-memory instructions and runs the memaccess state machine.
//  - Sits between the stage blocks and the instr/data memory interfaces.

---
 rtl/lc3_stage_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_lc3_stage_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/lc3_stage_sequencer.sv
// Central sequencer for the LC3 5-stage pipeline.
// Generates registered per-stage enables, refills the pipeline in order after
// reset and after taken branches, stalls around data-memory instructions and
// runs the memaccess state machine with a bounded wait.
//
// Ports:
//   clock            - rising-edge clock
//   reset            - asynchronous active-low reset
//   complete_instr   - instruction memory returned the word for this fetch
//   complete_data    - data memory completed the current access
//   ir_exec[15:0]    - instruction held in execute
//   nzp_wb[2:0]      - condition codes from writeback
//   enable_updatePC  - PC load enable
//   enable_fetch     - instruction memory read enable
//   enable_decode    - decode stage enable
//   enable_execute   - execute stage enable
//   enable_writeback - writeback stage enable
//   br_taken         - branch target select, one-cycle pulse
//   mem_state[1:0]   - 0=read, 1=indirect read, 2=write, 3=idle
//   mem_err          - one-cycle pulse when a memory wait times out
module lc3_stage_sequencer #(
  parameter int unsigned WAIT_LIMIT = 15,
  parameter int unsigned BR_BUBBLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        complete_instr,
  input  logic        complete_data,
  input  logic [15:0] ir_exec,
  input  logic [2:0]  nzp_wb,
  output logic        enable_updatePC,
  output logic        enable_fetch,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        br_taken,
  output logic [1:0]  mem_state,
  output logic        mem_err
);

  localparam int unsigned OP_W   = 4;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned WAIT_W = 4;

  localparam logic [OP_W-1:0] OP_BR  = 4'd0;
  localparam logic [OP_W-1:0] OP_LD  = 4'd2;
  localparam logic [OP_W-1:0] OP_ST  = 4'd3;
  localparam logic [OP_W-1:0] OP_LDR = 4'd6;
  localparam logic [OP_W-1:0] OP_STR = 4'd7;
  localparam logic [OP_W-1:0] OP_LDI = 4'd10;
  localparam logic [OP_W-1:0] OP_STI = 4'd11;
  localparam logic [OP_W-1:0] OP_JMP = 4'd12;

  typedef enum logic [1:0] {
    MS_READ  = 2'd0,
    MS_IND   = 2'd1,
    MS_WRITE = 2'd2,
    MS_IDLE  = 2'd3
  } mem_state_e;

  mem_state_e          ms_q;
  logic                is_store_q;
  logic [WAIT_W-1:0]   wait_q;
  logic [CNT_W-1:0]    fill_q;
  logic [CNT_W-1:0]    bub_q;
  logic                run_q;

  logic [OP_W-1:0]     opcode_c;
  logic                is_mem_c;
  logic                is_store_c;
  mem_state_e          mem_first_c;
  logic                mem_op_c;
  logic                br_take_c;
  logic [CNT_W-1:0]    fill_inc_c;
  logic                unused_c;

  assign opcode_c = ir_exec[15:12];
  assign unused_c = ^ir_exec[8:0];

  // Classify memory opcodes and pick the first memaccess state.
  always_comb begin
    is_mem_c    = 1'b0;
    is_store_c  = 1'b0;
    mem_first_c = MS_IDLE;
    case (opcode_c)
      OP_LD, OP_LDR: begin
        is_mem_c    = 1'b1;
        mem_first_c = MS_READ;
      end
      OP_LDI: begin
        is_mem_c    = 1'b1;
        mem_first_c = MS_IND;
      end
      OP_ST, OP_STR: begin
        is_mem_c    = 1'b1;
        is_store_c  = 1'b1;
        mem_first_c = MS_WRITE;
      end
      OP_STI: begin
        is_mem_c    = 1'b1;
        is_store_c  = 1'b1;
        mem_first_c = MS_IND;
      end
      default: ;
    endcase
  end

  assign mem_op_c   = enable_execute && is_mem_c;
  assign br_take_c  = enable_execute &&
                      (((opcode_c == OP_BR) && ((ir_exec[11:9] & nzp_wb) != 3'b000)) ||
                       (opcode_c == OP_JMP));
  assign fill_inc_c = (fill_q == 2'd3) ? 2'd3 : CNT_W'(fill_q + 2'd1);
  assign mem_state  = ms_q;

  // Sequencer: stall > fetch hold > branch > normal fill/run.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ms_q             <= MS_IDLE;
      is_store_q       <= 1'b0;
      wait_q           <= '0;
      fill_q           <= '0;
      bub_q            <= '0;
      run_q            <= 1'b0;
      enable_updatePC  <= 1'b0;
      enable_fetch     <= 1'b0;
      enable_decode    <= 1'b0;
      enable_execute   <= 1'b0;
      enable_writeback <= 1'b0;
      br_taken         <= 1'b0;
      mem_err          <= 1'b0;
    end else begin
      br_taken <= 1'b0;
      mem_err  <= 1'b0;
      if (ms_q != MS_IDLE) begin
        // Full stall while an access is in flight.
        enable_updatePC  <= 1'b0;
        enable_fetch     <= 1'b0;
        enable_decode    <= 1'b0;
        enable_execute   <= 1'b0;
        enable_writeback <= 1'b0;
        if (complete_data) begin
          wait_q <= '0;
          case (ms_q)
            MS_IND:  ms_q <= is_store_q ? MS_WRITE : MS_READ;
            MS_READ: begin
              ms_q             <= MS_IDLE;
              enable_writeback <= 1'b1;
            end
            default: ms_q <= MS_IDLE;
          endcase
        end else if (wait_q == WAIT_W'(WAIT_LIMIT - 1)) begin
          // Timeout: drop the instruction, no retry.
          ms_q    <= MS_IDLE;
          wait_q  <= '0;
          mem_err <= 1'b1;
        end else begin
          wait_q <= WAIT_W'(wait_q + 4'd1);
        end
      end else if (mem_op_c) begin
        ms_q             <= mem_first_c;
        is_store_q       <= is_store_c;
        wait_q           <= '0;
        enable_updatePC  <= 1'b0;
        enable_fetch     <= 1'b0;
        enable_decode    <= 1'b0;
        enable_execute   <= 1'b0;
        enable_writeback <= 1'b0;
      end else if (enable_fetch && !complete_instr) begin
        enable_updatePC  <= 1'b0;
        enable_fetch     <= 1'b1;
        enable_decode    <= 1'b0;
        enable_execute   <= 1'b0;
        enable_writeback <= 1'b0;
      end else if (br_take_c) begin
        // Flush downstream stages, then refill after the bubbles.
        br_taken         <= 1'b1;
        fill_q           <= '0;
        bub_q            <= CNT_W'(BR_BUBBLES - 1);
        enable_updatePC  <= 1'b1;
        enable_fetch     <= 1'b1;
        enable_decode    <= 1'b0;
        enable_execute   <= 1'b0;
        enable_writeback <= 1'b0;
      end else if (!run_q) begin
        // First clock after reset: only PC update and fetch.
        run_q            <= 1'b1;
        enable_updatePC  <= 1'b1;
        enable_fetch     <= 1'b1;
        enable_decode    <= 1'b0;
        enable_execute   <= 1'b0;
        enable_writeback <= 1'b0;
      end else begin
        enable_updatePC <= 1'b1;
        enable_fetch    <= 1'b1;
        if (bub_q != '0) begin
          bub_q            <= CNT_W'(bub_q - 2'd1);
          enable_decode    <= 1'b0;
          enable_execute   <= 1'b0;
          enable_writeback <= 1'b0;
        end else begin
          fill_q           <= fill_inc_c;
          enable_decode    <= 1'b1;
          enable_execute   <= (fill_inc_c >= 2'd2);
          enable_writeback <= (fill_inc_c == 2'd3);
        end
      end
    end
  end

endmodule

// File: tb/tb_lc3_stage_sequencer.sv
// Directed bench for lc3_stage_sequencer: reset, fill, memory stalls,
// branches, fetch hold, wait timeout and reset during a stall.
module tb_lc3_stage_sequencer;

  logic        clock;
  logic        reset;
  logic        complete_instr;
  logic        complete_data;
  logic [15:0] ir_exec;
  logic [2:0]  nzp_wb;
  logic        enable_updatePC;
  logic        enable_fetch;
  logic        enable_decode;
  logic        enable_execute;
  logic        enable_writeback;
  logic        br_taken;
  logic [1:0]  mem_state;
  logic        mem_err;

  int n_vec;
  int n_err;

  localparam logic [15:0] I_ADD = 16'h1000;

  lc3_stage_sequencer #(.WAIT_LIMIT(15), .BR_BUBBLES(2)) dut (
    .clock            (clock),
    .reset            (reset),
    .complete_instr   (complete_instr),
    .complete_data    (complete_data),
    .ir_exec          (ir_exec),
    .nzp_wb           (nzp_wb),
    .enable_updatePC  (enable_updatePC),
    .enable_fetch     (enable_fetch),
    .enable_decode    (enable_decode),
    .enable_execute   (enable_execute),
    .enable_writeback (enable_writeback),
    .br_taken         (br_taken),
    .mem_state        (mem_state),
    .mem_err          (mem_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // en order: {updatePC, fetch, decode, execute, writeback}
  task automatic check_all(input string tag, input logic [4:0] en, input logic [1:0] ms,
                           input logic br, input logic err);
    check({tag, ".en"}, 16'({enable_updatePC, enable_fetch, enable_decode,
                             enable_execute, enable_writeback}), 16'(en));
    check({tag, ".ms"}, 16'(mem_state), 16'(ms));
    check({tag, ".br"}, 16'(br_taken), 16'(br));
    check({tag, ".err"}, 16'(mem_err), 16'(err));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_vec          = 0;
    n_err          = 0;
    reset          = 1'b0;
    complete_instr = 1'b1;
    complete_data  = 1'b0;
    ir_exec        = I_ADD;
    nzp_wb         = 3'b000;

    // Reset values
    #12;
    check_all("rst", 5'b00000, 2'd3, 1'b0, 1'b0);
    step();
    reset = 1'b1;

    // 1. Fill after reset
    step(); check_all("fill1", 5'b11000, 2'd3, 1'b0, 1'b0);
    step(); check_all("fill2", 5'b11100, 2'd3, 1'b0, 1'b0);
    step(); check_all("fill3", 5'b11110, 2'd3, 1'b0, 1'b0);
    step(); check_all("fill4", 5'b11111, 2'd3, 1'b0, 1'b0);
    step(); check_all("run",   5'b11111, 2'd3, 1'b0, 1'b0);

    // 2. LDI: mem_state 1,1,0,0,0,3 then restore
    ir_exec = 16'hA000;
    step(); check_all("ldi1", 5'b00000, 2'd1, 1'b0, 1'b0);
    ir_exec = I_ADD;
    step(); check_all("ldi2", 5'b00000, 2'd1, 1'b0, 1'b0);
    complete_data = 1'b1;
    step(); check_all("ldi3", 5'b00000, 2'd0, 1'b0, 1'b0);
    complete_data = 1'b0;
    step(); check_all("ldi4", 5'b00000, 2'd0, 1'b0, 1'b0);
    step(); check_all("ldi5", 5'b00000, 2'd0, 1'b0, 1'b0);
    complete_data = 1'b1;
    step(); check_all("ldi6", 5'b00001, 2'd3, 1'b0, 1'b0);
    complete_data = 1'b0;
    step(); check_all("ldi7", 5'b11111, 2'd3, 1'b0, 1'b0);

    // LD single read
    ir_exec = 16'h2000;
    step(); check_all("ld1", 5'b00000, 2'd0, 1'b0, 1'b0);
    ir_exec = I_ADD;
    complete_data = 1'b1;
    step(); check_all("ld2", 5'b00001, 2'd3, 1'b0, 1'b0);
    complete_data = 1'b0;
    step(); check_all("ld3", 5'b11111, 2'd3, 1'b0, 1'b0);

    // 3. BRz taken with Z set: two bubbles then refill
    ir_exec = 16'h0400;
    nzp_wb  = 3'b010;
    step(); check_all("brz0", 5'b11000, 2'd3, 1'b1, 1'b0);
    ir_exec = I_ADD;
    step(); check_all("brz1", 5'b11000, 2'd3, 1'b0, 1'b0);
    step(); check_all("brz2", 5'b11100, 2'd3, 1'b0, 1'b0);
    step(); check_all("brz3", 5'b11110, 2'd3, 1'b0, 1'b0);
    step(); check_all("brz4", 5'b11111, 2'd3, 1'b0, 1'b0);

    // 4. BRn not taken with P set
    ir_exec = 16'h0800;
    nzp_wb  = 3'b001;
    step(); check_all("brn0", 5'b11111, 2'd3, 1'b0, 1'b0);
    ir_exec = I_ADD;
    step(); check_all("brn1", 5'b11111, 2'd3, 1'b0, 1'b0);

    // JMP always taken
    ir_exec = 16'hC000;
    nzp_wb  = 3'b000;
    step(); check_all("jmp0", 5'b11000, 2'd3, 1'b1, 1'b0);
    ir_exec = I_ADD;
    step(); check_all("jmp1", 5'b11000, 2'd3, 1'b0, 1'b0);
    step(); check_all("jmp2", 5'b11100, 2'd3, 1'b0, 1'b0);
    step(); step(); check_all("jmp4", 5'b11111, 2'd3, 1'b0, 1'b0);

    // Fetch hold
    complete_instr = 1'b0;
    step(); check_all("fh0", 5'b01000, 2'd3, 1'b0, 1'b0);
    step(); check_all("fh1", 5'b01000, 2'd3, 1'b0, 1'b0);
    complete_instr = 1'b1;
    step(); check_all("fh2", 5'b11111, 2'd3, 1'b0, 1'b0);

    // 5. STR with complete_data stuck low: 15 cycles in state 2, then mem_err
    ir_exec = 16'h7000;
    step(); check_all("str0", 5'b00000, 2'd2, 1'b0, 1'b0);
    ir_exec = I_ADD;
    for (int i = 1; i < 15; i++) begin
      step(); check_all($sformatf("strw%0d", i), 5'b00000, 2'd2, 1'b0, 1'b0);
    end
    step(); check_all("strerr", 5'b00000, 2'd3, 1'b0, 1'b1);
    step(); check_all("strrec", 5'b11111, 2'd3, 1'b0, 1'b0);

    // 6. Reset during STI state 1
    ir_exec = 16'hB000;
    step(); check_all("sti1", 5'b00000, 2'd1, 1'b0, 1'b0);
    ir_exec = I_ADD;
    #2;
    reset = 1'b0;
    #1;
    check_all("strst", 5'b00000, 2'd3, 1'b0, 1'b0);
    step(); check_all("strst2", 5'b00000, 2'd3, 1'b0, 1'b0);
    reset = 1'b1;
    step(); check_all("refill1", 5'b11000, 2'd3, 1'b0, 1'b0);
    step(); check_all("refill2", 5'b11100, 2'd3, 1'b0, 1'b0);
    step(); check_all("refill3", 5'b11110, 2'd3, 1'b0, 1'b0);
    step(); check_all("refill4", 5'b11111, 2'd3, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
